// File: rtl/gate_sensor_fsm.sv
// Gate sensor sequencer: decodes the outer/inner photo beams into entry, exit and error pulses.
// Define GATE_DEBOUNCE_EN to insert a per-sensor debounce filter after the synchronizers.
//
// state | meaning
// IDLE  | no car in the gate, waiting for the first beam
// EN1   | entering: outer beam only
// EN2   | entering: both beams
// EN3   | entering: inner beam only, INC on release
// EX1   | exiting: inner beam only
// EX2   | exiting: both beams
// EX3   | exiting: outer beam only, DEC on release
module gate_sensor_fsm #(
    parameter int unsigned DB_CYCLES = 10'd1000,
    parameter int unsigned DB_W      = 10
) (
    input  logic CLOCK_50,
    input  logic RST,
    input  logic SENS_A,
    input  logic SENS_B,
    output logic INC,
    output logic DEC,
    output logic ERR,
    output logic BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        EN1,
        EN2,
        EN3,
        EX1,
        EX2,
        EX3
    } state_t;

    if (DB_CYCLES < 1 || DB_CYCLES >= (32'd1 << DB_W)) begin : g_bad_cfg
        $error("gate_sensor_fsm: DB_CYCLES must be in 1 .. 2**DB_W-1");
    end

    logic a_s1, a_s2, b_s1, b_s2;
    logic a_f, b_f;
    logic [1:0] code;

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
        end else begin
            a_s1 <= SENS_A;
            a_s2 <= a_s1;
            b_s1 <= SENS_B;
            b_s2 <= b_s1;
        end
    end

`ifdef GATE_DEBOUNCE_EN
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] cnt_a, cnt_b;

    // Count consecutive disagreements; any agreement restarts the run.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            a_f   <= 1'b0;
            cnt_a <= '0;
        end else if (a_s2 != a_f) begin
            if (cnt_a == DB_LAST) begin
                a_f   <= a_s2;
                cnt_a <= '0;
            end else begin
                cnt_a <= cnt_a + 1'b1;
            end
        end else begin
            cnt_a <= '0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            b_f   <= 1'b0;
            cnt_b <= '0;
        end else if (b_s2 != b_f) begin
            if (cnt_b == DB_LAST) begin
                b_f   <= b_s2;
                cnt_b <= '0;
            end else begin
                cnt_b <= cnt_b + 1'b1;
            end
        end else begin
            cnt_b <= '0;
        end
    end
`else
    assign a_f = a_s2;
    assign b_f = b_s2;
`endif

    assign code = {a_f, b_f};

    state_t state, state_nxt;
    logic   inc_nxt, dec_nxt, err_nxt;

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state <= IDLE;
            INC   <= 1'b0;
            DEC   <= 1'b0;
            ERR   <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_nxt;
            INC   <= inc_nxt;
            DEC   <= dec_nxt;
            ERR   <= err_nxt;
            BUSY  <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        inc_nxt   = 1'b0;
        dec_nxt   = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                case (code)
                    2'b10:   state_nxt = EN1;
                    2'b01:   state_nxt = EX1;
                    2'b11:   err_nxt   = 1'b1;
                    default: state_nxt = IDLE;
                endcase
            end
            EN1: begin
                case (code)
                    2'b11:   state_nxt = EN2;
                    2'b00:   state_nxt = IDLE;
                    2'b01: begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                    default: state_nxt = EN1;
                endcase
            end
            EN2: begin
                case (code)
                    2'b01:   state_nxt = EN3;
                    2'b10:   state_nxt = EN1;
                    2'b00: begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                    default: state_nxt = EN2;
                endcase
            end
            EN3: begin
                case (code)
                    2'b00: begin
                        state_nxt = IDLE;
                        inc_nxt   = 1'b1;
                    end
                    2'b11:   state_nxt = EN2;
                    2'b10: begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                    default: state_nxt = EN3;
                endcase
            end
            // Exit states are the entry states with the beams swapped.
            EX1: begin
                case (code)
                    2'b11:   state_nxt = EX2;
                    2'b00:   state_nxt = IDLE;
                    2'b10: begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                    default: state_nxt = EX1;
                endcase
            end
            EX2: begin
                case (code)
                    2'b10:   state_nxt = EX3;
                    2'b01:   state_nxt = EX1;
                    2'b00: begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                    default: state_nxt = EX2;
                endcase
            end
            EX3: begin
                case (code)
                    2'b00: begin
                        state_nxt = IDLE;
                        dec_nxt   = 1'b1;
                    end
                    2'b11:   state_nxt = EX2;
                    2'b01: begin
                        state_nxt = IDLE;
                        err_nxt   = 1'b1;
                    end
                    default: state_nxt = EX3;
                endcase
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_gate_sensor_fsm.sv
// Randomized bench for gate_sensor_fsm: a sequence-progress reference model feeds an event
// scoreboard; a negedge monitor checks every pulse, BUSY each cycle, and pulse exclusivity.
module tb_gate_sensor_fsm;

    localparam int NMAX = 16384;
`ifdef GATE_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 1000;
`endif
    // Beam code order for a complete pass: [0] entry, [1] exit.
    localparam logic [1:0] SEQ [2][3] = '{'{2'b10, 2'b11, 2'b01}, '{2'b01, 2'b11, 2'b10}};

    typedef struct {
        int kind;   // 0 INC, 1 DEC, 2 ERR
        int cyc;
    } ev_t;

    logic CLOCK_50 = 1'b1;
    logic RST      = 1'b1;
    logic SENS_A   = 1'b0;
    logic SENS_B   = 1'b0;
    logic INC, DEC, ERR, BUSY;

    gate_sensor_fsm #(.DB_CYCLES(DB), .DB_W(10)) dut (
        .CLOCK_50(CLOCK_50),
        .RST(RST),
        .SENS_A(SENS_A),
        .SENS_B(SENS_B),
        .INC(INC),
        .DEC(DEC),
        .ERR(ERR),
        .BUSY(BUSY)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    logic [1:0] raw_h    [NMAX];
    bit         rst_h    [NMAX];
    bit         busy_exp [NMAX];
    bit         busy_set [NMAX];
    ev_t        exp_q[$];

    int   m_step = 0;
    int   m_dir  = 0;
    logic fa = 1'b0, fb = 1'b0;
    int   ca = 0, cb = 0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic fsm_ref(input logic [1:0] c, input int e);
        ev_t ev;
        ev.cyc = e;
        if (m_step == 0) begin
            if (c == SEQ[0][0]) begin
                m_dir = 0; m_step = 1;
            end else if (c == SEQ[1][0]) begin
                m_dir = 1; m_step = 1;
            end else if (c == 2'b11) begin
                ev.kind = 2; exp_q.push_back(ev);
            end
        end else if (c == SEQ[m_dir][m_step-1]) begin
            m_step = m_step;
        end else if (m_step < 3 && c == SEQ[m_dir][m_step]) begin
            m_step = m_step + 1;
        end else if (m_step >= 2 && c == SEQ[m_dir][m_step-2]) begin
            m_step = m_step - 1;
        end else if (c == 2'b00 && m_step == 1) begin
            m_step = 0;
        end else if (c == 2'b00 && m_step == 3) begin
            ev.kind = m_dir; exp_q.push_back(ev);
            m_step = 0;
        end else begin
            ev.kind = 2; exp_q.push_back(ev);
            m_step = 0;
        end
    endtask

    // Evaluate what the design does at rising edge e.
    task automatic model_edge(input int e);
        logic [1:0] sc, fc;
        sc = (e <= 2 || rst_h[e-1] || rst_h[e-2]) ? 2'b00 : raw_h[e-2];
`ifdef GATE_DEBOUNCE_EN
        fc = {fa, fb};
        if (rst_h[e]) begin
            fa = 1'b0; fb = 1'b0; ca = 0; cb = 0;
        end else begin
            if (sc[1] != fa) begin
                ca++;
                if (ca == DB) begin fa = sc[1]; ca = 0; end
            end else ca = 0;
            if (sc[0] != fb) begin
                cb++;
                if (cb == DB) begin fb = sc[0]; cb = 0; end
            end else cb = 0;
        end
`else
        fc = sc;
`endif
        if (rst_h[e]) begin
            m_step = 0; m_dir = 0;
        end else begin
            fsm_ref(fc, e);
        end
        busy_exp[e] = (m_step != 0);
        busy_set[e] = 1'b1;
    endtask

    task automatic step(input logic [1:0] c, input bit r);
        int e;
        @(negedge CLOCK_50);
        e = cyc + 1;
        raw_h[e] = c;
        rst_h[e] = r;
        SENS_A   = c[1];
        SENS_B   = c[0];
        RST      = r;
        model_edge(e);
    endtask

    task automatic drive(input logic [1:0] c, input int hold);
        for (int i = 0; i < hold; i++) step(c, 1'b0);
    endtask

    task automatic drive_pass(input int d, input int hold, input bit back);
        drive(2'b00, hold);
        drive(SEQ[d][0], hold);
        drive(SEQ[d][1], hold);
        if (back) begin
            drive(SEQ[d][0], hold);
            drive(SEQ[d][1], hold);
        end
        drive(SEQ[d][2], hold);
        drive(2'b00, hold);
    endtask

    always @(negedge CLOCK_50) begin
        int  kind;
        ev_t ev;
        if (cyc > 0 && cyc < NMAX && busy_set[cyc]) begin
            n_tests++;
            if (BUSY !== busy_exp[cyc]) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, BUSY, busy_exp[cyc]);
            end
            n_tests++;
            if ($countones({INC, DEC, ERR}) > 1) begin
                n_fail++;
                $display("FAIL exclusive cyc=%0d got inc/dec/err=%b%b%b exp at most one", cyc, INC, DEC, ERR);
            end
            if (INC === 1'b1 || DEC === 1'b1 || ERR === 1'b1) begin
                kind = (INC === 1'b1) ? 0 : (DEC === 1'b1) ? 1 : 2;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_pulse cyc=%0d got kind=%0d exp none", cyc, kind);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.kind != kind || ev.cyc != cyc) begin
                        n_fail++;
                        $display("FAIL pulse got kind=%0d cyc=%0d exp kind=%0d cyc=%0d", kind, cyc, ev.kind, ev.cyc);
                    end
                end
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                ev = exp_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL missed_pulse cyc=%0d got none exp kind=%0d at cyc=%0d", cyc, ev.kind, ev.cyc);
            end
        end
    end

    initial begin
        #(NMAX * 10 + 2000);
        $display("FAIL timeout got cyc=%0d exp finish", cyc);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int sel;
        for (int i = 0; i < 3; i++) step(2'b00, 1'b1);
        drive(2'b00, 5);

        // Directed passes: entry, exit, back-out, illegal 11, reset mid-sequence.
        drive_pass(0, 5, 1'b0);
        drive_pass(1, 5, 1'b0);
        drive(2'b00, 5); drive(2'b10, 5); drive(2'b11, 5); drive(2'b10, 5); drive(2'b00, 5);
        drive(2'b00, 5); drive(2'b11, 5); drive(2'b00, 5);
        drive(2'b10, 5); drive(2'b11, 5); step(2'b11, 1'b1); drive(2'b01, 5); drive(2'b00, 8);
`ifdef GATE_DEBOUNCE_EN
        drive(2'b00, 10); drive(2'b10, 3); drive(2'b00, 12);
        drive_pass(0, 6, 1'b0);
        drive(2'b00, 12);
`endif

        while (cyc < 12000) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1: drive_pass(0, $urandom_range(1, 7), ($urandom_range(0, 3) == 0));
                2:    drive_pass(1, $urandom_range(1, 7), ($urandom_range(0, 3) == 0));
                3: begin
                    for (int k = 0; k < $urandom_range(1, 6); k++)
                        drive(2'($urandom_range(0, 3)), $urandom_range(1, 7));
                end
                4: begin
                    for (int k = 0; k < $urandom_range(1, 2); k++) step(2'($urandom_range(0, 3)), 1'b1);
                end
                default: drive(2'b00, $urandom_range(1, 8));
            endcase
        end

        drive(2'b00, 2 * DB + 12 < 40 ? 2 * DB + 12 : 40);
        @(negedge CLOCK_50);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_events got %0d exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
